claw_stepper_driver: RTL and testbench
======================================

Name: claw_stepper_driver

Overview:
- Responder end of the claw command interface: accepts the 3-valued claw direction command (up / down / stop) from the robot controller and drives the 4-coil claw stepper.
- Generates the two-phase full-step coil sequence at a fixed step rate.
- Tracks claw position in steps and enforces top/bottom travel limits.
- De-energises the coils after a hold timeout.

Parameters:
STEP_DIV, 2000, clock cycles per motor step (>=2)
MAX_STEPS, 400, bottom travel limit in steps from top
HOLD_CYCLES, 50000, cycles in HOLD before coils are released (>=1)
POS_W, 16, width of position counter (must hold MAX_STEPS)

Ports:
clk  input  1  system clock
rst  input  1  reset, asynchronous, active-high
dir  input  2  claw command: 0 = up, 1 = down, 2 = stop, 3 = treated as stop
c_motor  output  4  coil drive, bit 0 = coil A
pos  output  POS_W  current position, 0 = top
at_top  output  1  high when pos == 0
at_bottom  output  1  high when pos == MAX_STEPS
busy  output  1  high in MOVE_UP or MOVE_DOWN
step_pulse  output  1  one-cycle strobe on each executed step

Behaviour:
- Reset state (asynchronous, all registered outputs):
  - state = RELEASED, phase index = 0, prescaler = 0, hold timer = 0.
  - pos = 0, c_motor = 0000, busy = 0, step_pulse = 0, at_top = 1, at_bottom = 0.
  - The position at reset defines the top.
- Phase table: idx 0..3 = 1100, 0110, 0011, 1001.
  - Down steps increment idx mod 4; up steps decrement idx mod 4 (0 wraps to 3).
- c_motor = PHASE[idx] in every state except RELEASED; 0000 in RELEASED.
  - c_motor is registered: it reflects state and idx after each edge.
- dir is sampled on every rising clk edge; there is no internal synchroniser because the caller is synchronous to clk.
- State machine: RELEASED, HOLD, MOVE_UP, MOVE_DOWN.
  - RELEASED / HOLD:
    - dir = down and pos < MAX_STEPS → MOVE_DOWN.
    - dir = up and pos > 0 → MOVE_UP.
    - Otherwise remain.
    - Entering a MOVE state clears the prescaler; coils energise with the current idx on that edge.
  - HOLD: hold timer increments each cycle and is cleared on entry. When it reaches HOLD_CYCLES-1 → RELEASED.
  - MOVE_DOWN: prescaler increments each cycle. When prescaler == STEP_DIV-1:
    - prescaler = 0, idx+1, pos+1, step_pulse = 1 for that cycle.
    - If the new pos == MAX_STEPS → HOLD, even if dir is still down.
  - MOVE_UP: mirror of MOVE_DOWN with idx-1 and pos-1; new pos == 0 → HOLD.
  - In either MOVE state, dir = stop or invalid → HOLD on the next edge. No partial step; the prescaler is discarded.
  - MOVE_DOWN with dir = up (or MOVE_UP with dir = down) → opposite MOVE state directly (respecting its limit, else HOLD); prescaler cleared.
  - The direction-change check and the step check fall on the same edge: the step in the current direction executes first, then the transition.
- Step latency: first step edge occurs exactly STEP_DIV cycles after the edge entering MOVE; subsequent steps every STEP_DIV cycles.
- Limit requests: down at pos == MAX_STEPS and up at pos == 0 are ignored. The block stays in HOLD/RELEASED and the hold timer is not cleared.
- pos never wraps, never exceeds MAX_STEPS, never goes below 0.
- at_top, at_bottom and busy are decoded from registered state/pos and update on the same edge as pos/state.
- Reset asserted mid-move: immediate return to reset values; no step_pulse.

Test Plan:
- STEP_DIV=4, MAX_STEPS=5, HOLD_CYCLES=8; release rst, dir = stop → c_motor = 0000, pos = 0, at_top = 1, busy = 0 indefinitely.
- dir = down held → MOVE_DOWN; c_motor 1100 → 0110 → 0011 → 1001 → 1100 → 0110. step_pulse every 4 cycles, 5 pulses total. pos reaches 5, at_bottom = 1, busy = 0; then 8 cycles later c_motor = 0000.
- From pos = 5 with dir = up held → idx decrements each step, pos 5 → 0, at_top = 1; a further up request produces no step_pulse.
- dir = down for 6 cycles then stop → exactly 1 step (pos = 1), HOLD with coils energised; dir = down again within 8 cycles → first new step 4 cycles after re-entry.
- Moving down at pos = 2, switch dir to up 2 cycles after a step → no step on the switch edge, next step (up) 4 cycles later, pos = 1.
- Assert rst 2 cycles into a move at pos = 3 → same-cycle c_motor = 0000, pos = 0, busy = 0, no step_pulse.

Source files
------------

// File: rtl/claw_stepper_driver.sv
// Claw stepper driver: takes the up/down/stop claw command and drives a 4-coil
// stepper with the full-step sequence, travel limits and a hold-timeout release.
module claw_stepper_driver #(
    parameter int STEP_DIV    = 2000,
    parameter int MAX_STEPS   = 400,
    parameter int HOLD_CYCLES = 50000,
    parameter int POS_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       dir,
    output logic [3:0]       c_motor,
    output logic [POS_W-1:0] pos,
    output logic             at_top,
    output logic             at_bottom,
    output logic             busy,
    output logic             step_pulse
);

    localparam int PRE_W  = $clog2(STEP_DIV);
    localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(STEP_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [POS_W-1:0]  POS_MAX   = POS_W'(MAX_STEPS);

    localparam logic [1:0] DIR_UP   = 2'd0;
    localparam logic [1:0] DIR_DOWN = 2'd1;

    typedef enum logic [1:0] {
        S_RELEASED,
        S_HOLD,
        S_MOVE_UP,
        S_MOVE_DOWN
    } state_t;

    state_t            state_q, state_d;
    logic [1:0]        idx_q, idx_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [POS_W-1:0]  pos_q, pos_d;
    logic [3:0]        c_motor_q, c_motor_d;
    logic              step_q, step_d;
    logic              moving_down;

    function automatic logic [3:0] phase_of(input logic [1:0] i);
        case (i)
            2'd0:    phase_of = 4'b1100;
            2'd1:    phase_of = 4'b0110;
            2'd2:    phase_of = 4'b0011;
            default: phase_of = 4'b1001;
        endcase
    endfunction

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d     = state_q;
        idx_d       = idx_q;
        pre_d       = pre_q;
        hold_d      = '0;
        pos_d       = pos_q;
        step_d      = 1'b0;
        moving_down = (state_q == S_MOVE_DOWN);

        case (state_q)
            S_RELEASED, S_HOLD: begin
                // Requests into a limit fall through, so the hold timer keeps running.
                if (dir == DIR_DOWN && pos_q != POS_MAX) begin
                    state_d = S_MOVE_DOWN;
                    pre_d   = '0;
                end else if (dir == DIR_UP && pos_q != '0) begin
                    state_d = S_MOVE_UP;
                    pre_d   = '0;
                end else if (state_q == S_HOLD) begin
                    if (hold_q == HOLD_LAST) state_d = S_RELEASED;
                    else                     hold_d  = hold_q + 1'b1;
                end
            end

            default: begin
                pre_d = pre_q + 1'b1;
                if (pre_q == PRE_LAST) begin
                    pre_d  = '0;
                    step_d = 1'b1;
                    if (moving_down) begin
                        idx_d = idx_q + 2'd1;
                        pos_d = pos_q + 1'b1;
                    end else begin
                        idx_d = idx_q - 2'd1;
                        pos_d = pos_q - 1'b1;
                    end
                end
                // Direction decision uses the post-step position.
                if (dir == DIR_DOWN) begin
                    if (pos_d == POS_MAX) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_MOVE_DOWN;
                        if (!moving_down) pre_d = '0;
                    end
                end else if (dir == DIR_UP) begin
                    if (pos_d == '0) begin
                        state_d = S_HOLD;
                    end else begin
                        state_d = S_MOVE_UP;
                        if (moving_down) pre_d = '0;
                    end
                end else begin
                    state_d = S_HOLD;
                end
            end
        endcase

        c_motor_d = (state_d == S_RELEASED) ? 4'b0000 : phase_of(idx_d);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_RELEASED;
            idx_q     <= '0;
            pre_q     <= '0;
            hold_q    <= '0;
            pos_q     <= '0;
            c_motor_q <= 4'b0000;
            step_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            idx_q     <= idx_d;
            pre_q     <= pre_d;
            hold_q    <= hold_d;
            pos_q     <= pos_d;
            c_motor_q <= c_motor_d;
            step_q    <= step_d;
        end
    end

    assign c_motor    = c_motor_q;
    assign pos        = pos_q;
    assign step_pulse = step_q;
    assign at_top     = (pos_q == '0);
    assign at_bottom  = (pos_q == POS_MAX);
    assign busy       = (state_q == S_MOVE_UP) || (state_q == S_MOVE_DOWN);

endmodule

// File: tb/tb_claw_stepper_driver.sv
// Bench for claw_stepper_driver: directed scenarios plus random commands,
// all compared cycle by cycle against a position-based behavioural model.
module tb_claw_stepper_driver;

    localparam int STEP_DIV    = 4;
    localparam int MAX_STEPS   = 5;
    localparam int HOLD_CYCLES = 8;
    localparam int POS_W       = 16;

    localparam logic [1:0] D_UP   = 2'd0;
    localparam logic [1:0] D_DOWN = 2'd1;
    localparam logic [1:0] D_STOP = 2'd2;
    localparam logic [1:0] D_BAD  = 2'd3;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       dir = D_STOP;
    logic [3:0]       c_motor;
    logic [POS_W-1:0] pos;
    logic             at_top, at_bottom, busy, step_pulse;
    logic [23:0]      obs;

    int n_checks = 0;
    int n_fail   = 0;

    claw_stepper_driver #(
        .STEP_DIV(STEP_DIV), .MAX_STEPS(MAX_STEPS),
        .HOLD_CYCLES(HOLD_CYCLES), .POS_W(POS_W)
    ) dut (
        .clk(clk), .rst(rst), .dir(dir), .c_motor(c_motor), .pos(pos),
        .at_top(at_top), .at_bottom(at_bottom), .busy(busy), .step_pulse(step_pulse)
    );

    always #5 clk = ~clk;

    assign obs = {c_motor, pos, at_top, at_bottom, busy, step_pulse};

    // Model: motion is +1/-1/0, coil pattern follows pos mod 4 because
    // position and phase both start at zero and move together.
    int m_pos, m_move, m_elapsed, m_idle;
    bit m_on, m_step;

    function automatic void model_reset();
        m_pos = 0; m_move = 0; m_elapsed = 0; m_idle = 0; m_on = 0; m_step = 0;
    endfunction

    function automatic int want_of(input logic [1:0] d);
        if (d == D_DOWN) return 1;
        if (d == D_UP)   return -1;
        return 0;
    endfunction

    function automatic void model_step(input logic [1:0] d);
        int want;
        want   = want_of(d);
        m_step = 0;
        if (m_move == 0) begin
            if ((want == 1 && m_pos < MAX_STEPS) || (want == -1 && m_pos > 0)) begin
                m_move = want; m_elapsed = 0; m_on = 1;
            end else if (m_on) begin
                m_idle++;
                if (m_idle == HOLD_CYCLES) m_on = 0;
            end
        end else begin
            m_elapsed++;
            if (m_elapsed == STEP_DIV) begin
                m_pos += m_move; m_elapsed = 0; m_step = 1;
            end
            if (want == 0 || (want == 1 && m_pos == MAX_STEPS) || (want == -1 && m_pos == 0)) begin
                m_move = 0; m_idle = 0;
            end else if (want != m_move) begin
                m_move = want; m_elapsed = 0;
            end
        end
    endfunction

    function automatic logic [3:0] coil_of(input int p);
        case (p % 4)
            0:       return 4'b1100;
            1:       return 4'b0110;
            2:       return 4'b0011;
            default: return 4'b1001;
        endcase
    endfunction

    function automatic logic [23:0] exp_vec();
        logic [3:0] coils;
        coils = m_on ? coil_of(m_pos) : 4'b0000;
        return {coils, 16'(m_pos), m_pos == 0, m_pos == MAX_STEPS, m_move != 0, m_step};
    endfunction

    task automatic tick(input logic [1:0] d);
        dir = d;
        @(posedge clk);
        model_step(d);
        @(negedge clk);
    endtask

    task automatic test_reset();
        model_reset();
        rst = 1'b1;
        dir = D_STOP;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({c_motor, pos, at_top, at_bottom, busy, step_pulse} !== {4'b0000, 16'd0, 4'b1000}) begin
            n_fail++; $display("FAIL reset_values: got %h expected %h", obs, {4'b0000, 16'd0, 4'b1000});
        end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            tick((i < 8) ? D_STOP : ((i < 12) ? D_UP : D_BAD));
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL idle_after_reset cycle %0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        n_checks++;
        if (c_motor !== 4'b0000 || busy !== 1'b0 || at_top !== 1'b1) begin
            n_fail++; $display("FAIL idle_released: got c_motor=%b busy=%b at_top=%b expected 0000/0/1", c_motor, busy, at_top);
        end
    endtask

    task automatic test_sweep_down();
        logic [3:0] seq [5] = '{4'b0110, 4'b0011, 4'b1001, 4'b1100, 4'b0110};
        int pulses = 0;
        for (int i = 0; i < 22; i++) begin
            tick(D_DOWN);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL sweep_down cycle %0d: got %h expected %h", i, obs, exp_vec());
            end
            if (i == 0) begin
                n_checks++;
                if (c_motor !== 4'b1100) begin
                    n_fail++; $display("FAIL sweep_down_energise: got %b expected 1100", c_motor);
                end
            end
            if (step_pulse === 1'b1) begin
                if (pulses < 5) begin
                    n_checks++;
                    if (c_motor !== seq[pulses]) begin
                        n_fail++; $display("FAIL sweep_down_phase %0d: got %b expected %b", pulses, c_motor, seq[pulses]);
                    end
                end
                pulses++;
            end
        end
        n_checks++;
        if (pulses !== 5 || pos !== 16'd5 || at_bottom !== 1'b1 || busy !== 1'b0) begin
            n_fail++; $display("FAIL sweep_down_end: got pulses=%0d pos=%0d at_bottom=%b busy=%b expected 5/5/1/0",
                               pulses, pos, at_bottom, busy);
        end
        // Down requests at the bottom are ignored and must not restart the hold timer.
        for (int i = 0; i < 6; i++) begin
            tick(D_DOWN);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL bottom_hold cycle %0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        n_checks++;
        if (c_motor !== 4'b0110) begin
            n_fail++; $display("FAIL hold_still_energised: got %b expected 0110", c_motor);
        end
        tick(D_DOWN);
        n_checks++;
        if (c_motor !== 4'b0000 || step_pulse !== 1'b0) begin
            n_fail++; $display("FAIL hold_release: got c_motor=%b step=%b expected 0000/0", c_motor, step_pulse);
        end
    endtask

    task automatic test_sweep_up();
        logic [3:0] seq [5] = '{4'b1100, 4'b1001, 4'b0011, 4'b0110, 4'b1100};
        int pulses = 0;
        int late   = 0;
        for (int i = 0; i < 32; i++) begin
            tick(D_UP);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL sweep_up cycle %0d: got %h expected %h", i, obs, exp_vec());
            end
            if (step_pulse === 1'b1) begin
                if (pulses < 5) begin
                    n_checks++;
                    if (c_motor !== seq[pulses]) begin
                        n_fail++; $display("FAIL sweep_up_phase %0d: got %b expected %b", pulses, c_motor, seq[pulses]);
                    end
                end
                if (i >= 22) late++;
                pulses++;
            end
        end
        n_checks++;
        if (pulses !== 5 || late !== 0 || pos !== 16'd0 || at_top !== 1'b1) begin
            n_fail++; $display("FAIL sweep_up_end: got pulses=%0d late=%0d pos=%0d at_top=%b expected 5/0/0/1",
                               pulses, late, pos, at_top);
        end
    endtask

    task automatic test_stop_resume();
        int first = -1;
        for (int i = 0; i < 9; i++) begin
            tick((i < 6) ? D_DOWN : D_STOP);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL stop_resume cycle %0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        n_checks++;
        if (pos !== 16'd1 || busy !== 1'b0 || c_motor !== 4'b0110) begin
            n_fail++; $display("FAIL stop_hold: got pos=%0d busy=%b c_motor=%b expected 1/0/0110", pos, busy, c_motor);
        end
        for (int i = 0; i < 10 && first < 0; i++) begin
            tick(D_DOWN);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL resume cycle %0d: got %h expected %h", i, obs, exp_vec());
            end
            if (step_pulse === 1'b1) first = i;
        end
        n_checks++;
        if (first !== 4 || pos !== 16'd2) begin
            n_fail++; $display("FAIL resume_latency: got step at %0d pos=%0d expected 4/2", first, pos);
        end
    endtask

    task automatic test_reverse();
        int first = -1;
        tick(D_DOWN);
        for (int i = 0; i < 10 && first < 0; i++) begin
            tick(D_UP);
            n_checks++;
            if (obs !== exp_vec()) begin
                n_fail++; $display("FAIL reverse cycle %0d: got %h expected %h", i, obs, exp_vec());
            end
            if (step_pulse === 1'b1) first = i;
        end
        n_checks++;
        if (first !== 4 || pos !== 16'd1 || busy !== 1'b1) begin
            n_fail++; $display("FAIL reverse_step: got step at %0d pos=%0d busy=%b expected 4/1/1", first, pos, busy);
        end
    endtask

    task automatic test_mid_move_reset();
        tick(D_STOP);
        for (int i = 0; i < 20 && pos !== 16'd3; i++) tick(D_DOWN);
        tick(D_STOP);
        n_checks++;
        if (obs !== exp_vec() || pos !== 16'd3) begin
            n_fail++; $display("FAIL setup_pos3: got %h expected %h", obs, exp_vec());
        end
        tick(D_DOWN);
        tick(D_DOWN);
        rst = 1'b1;
        #1;
        n_checks++;
        if ({c_motor, pos, at_top, at_bottom, busy, step_pulse} !== {4'b0000, 16'd0, 4'b1000}) begin
            n_fail++; $display("FAIL async_reset: got %h expected %h", obs, {4'b0000, 16'd0, 4'b1000});
        end
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (step_pulse !== 1'b0 || obs !== exp_vec()) begin
            n_fail++; $display("FAIL reset_held: got %h expected %h", obs, exp_vec());
        end
        rst = 1'b0;
    endtask

    task automatic test_random();
        logic [1:0] d;
        int run_len;
        int left = 3000;
        while (left > 0) begin
            d       = 2'($urandom_range(0, 3));
            run_len = $urandom_range(1, 14);
            for (int i = 0; i < run_len && left > 0; i++) begin
                tick(d);
                left--;
                n_checks++;
                if (obs !== exp_vec()) begin
                    n_fail++; $display("FAIL random left=%0d dir=%0d: got %h expected %h", left, d, obs, exp_vec());
                end
            end
            if ($urandom_range(0, 99) == 0) begin
                rst = 1'b1;
                #1;
                model_reset();
                n_checks++;
                if (obs !== exp_vec()) begin
                    n_fail++; $display("FAIL random_reset: got %h expected %h", obs, exp_vec());
                end
                @(negedge clk);
                rst = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_sweep_down();
        test_sweep_up();
        test_stop_resume();
        test_reverse();
        test_mid_move_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
